led_mode_ctrl: RTL and testbench
================================

# led_mode_ctrl

Parametrised switch-to-LED controller for the lab board: drives `led` from the slide switches through one of four run-time modes selected by push button `pba`, with `pbb` as a mode-specific action button. Both buttons are synchronised and debounced internally; the switches are synchronised. The block sits directly between board pins and LEDs. It replaces the purely combinational switch/LED logic with a registered, clocked design.

## Interface
- `WIDTH`, 8: number of switches and LEDs (≥2).
- `DB_CYCLES`, 16: consecutive stable cycles required to accept a button level change (≥2).
- `TICK_DIV`, 1000: clock cycles per ROTATE/COUNT step (≥2).

- `clk`  in  1  system clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sw`  in  WIDTH  raw slide switches, asynchronous to `clk`.
- `pba`  in  1  raw mode button, active-low (0 = pressed).
- `pbb`  in  1  raw action button, active-low.
- `led`  out  WIDTH  registered LED drive, active-high.
- `mode`  out  2  registered current mode: PASS=0, LATCH=1, ROTATE=2, COUNT=3.

## Operation
- Reset values: `led`=0, `mode`=PASS, latch register=0, rotate register=0, counter=0, rotate direction=left, prescaler=0. Sync flops and debounced levels for both buttons=1 (released); switch sync flops=0.
- Switches: 2-flop synchroniser per bit, giving `sw_s`.
- Buttons: 2-flop sync, then debounce counter. The counter increments while the synced level ≠ debounced level and clears to 0 when they are equal. When it would reach DB_CYCLES, the debounced level flips and the counter clears. Press pulse (1 cycle, registered) = debounced 1→0 transition. Release generates nothing.
- Mode FSM: each `pba` press advances PASS→LATCH→ROTATE→COUNT→PASS.
- PASS: `led` ← `sw_s`. `pbb` ignored.
- LATCH: `pbb` press captures `sw_s` into latch; `led` ← latch. Latch is retained across mode changes and cleared only by reset.
- ROTATE: on entry, rotate register ← `sw_s` and direction ← left. Each tick rotates by 1 in the current direction, with wrap (MSB↔LSB). `pbb` press toggles direction. All-zero and all-one patterns stay constant.
- COUNT: on entry, counter keeps its value. Each tick counter += 1 modulo 2^WIDTH (all-ones wraps to 0). `pbb` press clears the counter to 0; press wins over a same-cycle tick.
- Tick: the prescaler counts 0..TICK_DIV-1 and emits a tick when at TICK_DIV-1. It clears to 0 on every mode change, so the first step after entry is exactly TICK_DIV cycles later.
- Simultaneous `pba` and `pbb` press pulses in the same cycle: mode advance only; `pbb` is discarded.
- `rst` asserted at any time: all state returns to reset values asynchronously. The first press after release requires a full debounce period.

## Timing
- Edge 1 is the first edge sampling a new, stable button level. Debounced level flips at edge DB_CYCLES+2, the press pulse is high after edge DB_CYCLES+3, and `mode` or the action takes effect at edge DB_CYCLES+4.
- Any bounce shorter than DB_CYCLES cycles produces no press.
- PASS: `sw` change to `led` = 3 edges (2 sync + output register).
- Other modes: `led` reflects the updated internal register 1 edge after it changes.
- No handshakes; all outputs are glitch-free registers.

## Configuration
- `LEDCTRL_COUNT_MODE_EN` defined: four modes as above.
- Undefined: COUNT mode and its counter are not built. The cycle is PASS→LATCH→ROTATE→PASS, and `mode` never reads 3.

## Structure
- Package `ledctrl_pkg`: mode type and encodings (PASS/LATCH/ROTATE/COUNT), rotate-direction constants.
- Sub-module `btn_debounce`, parameter DB_CYCLES, ports `clk`, `rst`, raw active-low `btn`, `level` out, `press` out. It holds the sync, counter and press pulse, and is instantiated twice.
- Top holds the switch sync, prescaler, mode FSM, per-mode registers and the output mux/register.

## Test plan
Overrides for all scenarios: WIDTH=8, DB_CYCLES=4, TICK_DIV=4.
- Reset, then `sw`=8'hA5 → `led`=8'h00 during reset; `led`=8'hA5 exactly 3 edges after the `sw` change; `mode`=0.
- `pba` low for 3 cycles then high (bounce) → no mode change. `pba` held low → `mode`=1 at edge 8.
- LATCH: `sw`=8'h3C, press `pbb`, then `sw`=8'hFF → `led` stays 8'h3C.
- ROTATE, entered with `sw`=8'h81 → `led` sequence 8'h03, 8'h06, 8'h0C at 4-cycle steps. After a `pbb` press, steps go right.
- COUNT from 8'hFE → 8'hFF then 8'h00. Same-cycle `pbb` press and tick → counter 0. `pba` and `pbb` pressed together → mode advances, counter unchanged.
- `rst` pulsed mid-ROTATE → `led`=0 and `mode`=0 immediately. With the macro undefined, four `pba` presses from PASS → `mode` 1, 2, 0, 1.

Source files
------------

// File: rtl/ledctrl_pkg.sv
// ledctrl_pkg: mode encodings and rotate-direction constants for led_mode_ctrl
package ledctrl_pkg;
  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_LATCH  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop sync, stability-count debounce and registered press pulse for an active-low button
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  logic s1_q, s2_q, level_q, level_d, prev_q, press_q;
  logic [CW-1:0] cnt_q, cnt_d;
  // count cycles of disagreement; flip the level when the count would reach DB_CYCLES
  always_comb begin
    cnt_d   = (s2_q == level_q || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    level_d = (s2_q != level_q && cnt_q == CNT_LAST) ? s2_q : level_q;
  end
  // sync flops, debounced level and a one-cycle pulse on the debounced 1->0 edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      press_q <= prev_q & ~level_q;
      cnt_q   <= cnt_d;
    end
  end
  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: switch-to-LED controller with PASS/LATCH/ROTATE(/COUNT) modes; COUNT built only with LEDCTRL_COUNT_MODE_EN
module led_mode_ctrl
  import ledctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 16,
  parameter int TICK_DIV  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             pba,
  input  logic             pbb,
  output logic [WIDTH-1:0] led,
  output logic [1:0]       mode
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  logic [WIDTH-1:0] sw1_q, sw_s_q, latch_q, latch_d, rot_q, rot_d, led_q, led_d;
  logic [PW-1:0] pre_q, pre_d;
  mode_e mode_q, mode_d;
  logic dir_q, dir_d;
  logic a_lvl, b_lvl, a_press, b_press, adv, act, tick, step, enter;
  logic unused_lvl;
`ifdef LEDCTRL_COUNT_MODE_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
`endif

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_pba (.clk(clk), .rst(rst), .btn(pba), .level(a_lvl), .press(a_press));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_pbb (.clk(clk), .rst(rst), .btn(pbb), .level(b_lvl), .press(b_press));

  assign unused_lvl = a_lvl ^ b_lvl;
  assign adv  = a_press;
  assign act  = b_press & ~a_press;
  assign tick = pre_q == PRE_LAST;
  assign step = tick & ~adv;

  // next mode, prescaler, per-mode registers and the LED mux
  always_comb begin
`ifdef LEDCTRL_COUNT_MODE_EN
    mode_d = adv ? mode_e'(mode_q + 2'd1) : mode_q;
`else
    mode_d = !adv ? mode_q : (mode_q == MODE_ROTATE) ? MODE_PASS : mode_e'(mode_q + 2'd1);
`endif
    enter   = adv && mode_d == MODE_ROTATE;
    pre_d   = (adv || tick) ? '0 : pre_q + 1'b1;
    latch_d = (mode_q == MODE_LATCH && act) ? sw_s_q : latch_q;
    rot_d   = enter ? sw_s_q :
              (mode_q == MODE_ROTATE && step) ?
                (dir_q == DIR_LEFT ? {rot_q[WIDTH-2:0], rot_q[WIDTH-1]} : {rot_q[0], rot_q[WIDTH-1:1]}) :
              rot_q;
    dir_d   = enter ? DIR_LEFT : (mode_q == MODE_ROTATE && act) ? ~dir_q : dir_q;
`ifdef LEDCTRL_COUNT_MODE_EN
    cnt_d   = (mode_q == MODE_COUNT && act) ? '0 :
              (mode_q == MODE_COUNT && step) ? cnt_q + 1'b1 : cnt_q;
`endif
    led_d   = (mode_q == MODE_LATCH)  ? latch_q :
              (mode_q == MODE_ROTATE) ? rot_q :
`ifdef LEDCTRL_COUNT_MODE_EN
              (mode_q == MODE_COUNT)  ? cnt_q :
`endif
              sw_s_q;
  end

  // switch synchroniser and all state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw1_q   <= '0;
      sw_s_q  <= '0;
      pre_q   <= '0;
      mode_q  <= MODE_PASS;
      latch_q <= '0;
      rot_q   <= '0;
      dir_q   <= DIR_LEFT;
      led_q   <= '0;
`ifdef LEDCTRL_COUNT_MODE_EN
      cnt_q   <= '0;
`endif
    end else begin
      sw1_q   <= sw;
      sw_s_q  <= sw1_q;
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      latch_q <= latch_d;
      rot_q   <= rot_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
`ifdef LEDCTRL_COUNT_MODE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed and randomized self-checking bench for led_mode_ctrl
module tb_led_mode_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] sw;
  logic pba, pbb;
  logic [7:0] led;
  logic [1:0] mode;
  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  int act = 0;
  int next_ok = 0;
  int e_rot, t_tog, e_cnt, c_clr, x_pair;
  logic [7:0] p, v;

  led_mode_ctrl #(.WIDTH(8), .DB_CYCLES(4), .TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .sw(sw), .pba(pba), .pbb(pbb), .led(led), .mode(mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at edge %0d", ecnt);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (ecnt < t) step(1);
  endtask

  // hold the selected buttons low long enough for one press; act = edge where it takes effect
  task automatic press(input bit a, input bit b);
    int e;
    wait_to(next_ok);
    e = ecnt;
    pba = a ? 1'b0 : 1'b1;
    pbb = b ? 1'b0 : 1'b1;
    wait_to(e + 9);
    pba = 1'b1;
    pbb = 1'b1;
    act = e + 8;
    next_ok = e + 16;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    check("rst_async_led", led, 8'h00);
    check("rst_async_mode", 8'(mode), 8'h00);
    step(1);
    rst = 1'b0;
    step(1);
    next_ok = ecnt;
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << (((n % 8) + 8) % 8);
    return d[15:8];
  endfunction

  // LED seen just after edge 'now': ticks every 4 edges after entry e, left until toggle edge t, right after
  function automatic logic [7:0] rot_exp(input logic [7:0] s, input int e, input int t, input int now);
    int tot, nl;
    tot = (now - 1 - e) / 4;
    nl  = (t > now - 1) ? tot : (t - e) / 4;
    return rotl(s, nl - (tot - nl));
  endfunction

  initial begin
    rst = 1'b1; sw = 8'h00; pba = 1'b1; pbb = 1'b1;
    step(3);
    check("reset_led", led, 8'h00);
    check("reset_mode", 8'(mode), 8'h00);
    sw = 8'hA5;
    step(1);
    check("led_in_reset", led, 8'h00);
    sw = 8'h00;
    rst = 1'b0;
    step(3);
    sw = 8'hA5;
    step(2);
    check("pass_edge2", led, 8'h00);
    step(1);
    check("pass_edge3", led, 8'hA5);
    check("pass_mode", 8'(mode), 8'h00);

    pba = 1'b0;
    step(3);
    pba = 1'b1;
    step(10);
    check("bounce_no_press", 8'(mode), 8'h00);

    e_rot = ecnt;
    pba = 1'b0;
    wait_to(e_rot + 7);
    check("press_edge7", 8'(mode), 8'h00);
    wait_to(e_rot + 8);
    check("press_edge8", 8'(mode), 8'h01);
    wait_to(e_rot + 9);
    pba = 1'b1;
    next_ok = e_rot + 16;

    sw = 8'h3C;
    step(3);
    check("latch_idle", led, 8'h00);
    press(1'b0, 1'b1);
    wait_to(act + 2);
    check("latch_capture", led, 8'h3C);
    sw = 8'hFF;
    step(5);
    check("latch_hold", led, 8'h3C);

    sw = 8'h81;
    step(3);
    press(1'b1, 1'b0);
    e_rot = act;
    wait_to(e_rot + 1);
    check("rot_entry", led, 8'h81);
    check("rot_mode", 8'(mode), 8'h02);
    wait_to(e_rot + 5);
    check("rot_step1", led, 8'h03);
    wait_to(e_rot + 9);
    check("rot_step2", led, 8'h06);
    wait_to(e_rot + 13);
    check("rot_step3", led, 8'h0C);
    press(1'b0, 1'b1);
    t_tog = act;
    wait_to(e_rot + 22);
    check("rot_before_right", led, 8'h30);
    wait_to(e_rot + 25);
    check("rot_right1", led, 8'h18);
    wait_to(e_rot + 29);
    check("rot_right2", led, 8'h0C);
    repeat (6) begin
      step($urandom_range(1, 6));
      check("rot_random_time", led, rot_exp(8'h81, e_rot, t_tog, ecnt));
    end
    pulse_rst();

    repeat (6) begin
      sw = 8'($urandom);
      step(3);
      check("pass_random", led, sw);
    end

    for (int i = 0; i < 4; i++) begin
      p = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom);
      sw = p;
      step(3);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      e_rot = act;
      repeat (4) begin
        step($urandom_range(1, 6));
        check("rot_pattern", led, rot_exp(p, e_rot, 1 << 30, ecnt));
      end
`ifdef LEDCTRL_COUNT_MODE_EN
      press(1'b1, 1'b0);
`endif
      press(1'b1, 1'b0);
      wait_to(act + 1);
      check("back_to_pass", 8'(mode), 8'h00);
    end

    pulse_rst();
`ifdef LEDCTRL_COUNT_MODE_EN
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    e_cnt = act;
    wait_to(e_cnt + 1);
    check("cnt_mode", 8'(mode), 8'h03);
    check("cnt_entry", led, 8'h00);
    wait_to(e_cnt + 1 + 4 * 254);
    check("cnt_fe", led, 8'hFE);
    wait_to(e_cnt + 1 + 4 * 255);
    check("cnt_ff", led, 8'hFF);
    wait_to(e_cnt + 1 + 4 * 256);
    check("cnt_wrap", led, 8'h00);
    wait_to(e_cnt + 1 + 4 * 259);
    wait_to(next_ok);
    while ((ecnt + 8 - e_cnt) % 4 != 0) step(1);
    press(1'b0, 1'b1);
    c_clr = act;
    wait_to(c_clr + 1);
    check("cnt_clear_wins", led, 8'h00);
    wait_to(c_clr + 5);
    check("cnt_after_clear", led, 8'h01);
    wait_to(next_ok);
    while ((ecnt + 8 - c_clr) % 4 != 2) step(1);
    press(1'b1, 1'b1);
    x_pair = act;
    v = 8'((x_pair - 1 - c_clr) / 4);
    sw = 8'h5A;
    wait_to(x_pair + 1);
    check("pair_mode_adv", 8'(mode), 8'h00);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    wait_to(act + 1);
    check("cnt_kept", led, v);
`else
    press(1'b1, 1'b0);
    wait_to(act + 1);
    check("cycle_1", 8'(mode), 8'h01);
    press(1'b1, 1'b0);
    wait_to(act + 1);
    check("cycle_2", 8'(mode), 8'h02);
    press(1'b1, 1'b0);
    wait_to(act + 1);
    check("cycle_wrap_0", 8'(mode), 8'h00);
    press(1'b1, 1'b0);
    wait_to(act + 1);
    check("cycle_1_again", 8'(mode), 8'h01);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
